// File: rtl/acp_stream_writer.sv
// Stream-to-memory write DMA driving the HPS f2h AXI3 slave (ACP path).
// Splits a byte-length transfer into INCR bursts that never cross a 4 KB page.
module acp_stream_writer #(
    parameter int          DATA_W          = 128,
    parameter int          ADDR_W          = 32,
    parameter int          ID_W            = 8,
    parameter int          MAX_BURST       = 16,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [3:0]  AWCACHE         = 4'b1111,
    parameter logic [4:0]  AWUSER          = 5'b00001
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [31:0]           cfg_len,
    input  logic                  cfg_start,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [1:0]            sts_err,
    output logic                  sts_cfg_err,

    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,

    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [3:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic [1:0]            m_awlock,
    output logic [2:0]            m_awprot,
    output logic [3:0]            m_awcache,
    output logic [4:0]            m_awuser,
    output logic                  m_awvalid,
    input  logic                  m_awready,

    output logic [ID_W-1:0]       m_wid,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,

    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        beats_left_q, beats_left_d;
    logic [4:0]         burst_q, burst_d;
    logic [4:0]         beat_cnt_q, beat_cnt_d;
    logic [OW-1:0]      outstanding_q, outstanding_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               cfg_err_q, cfg_err_d;

    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;
    logic               in_data;
    logic               cfg_misaligned;
    logic [12:0]        to_4k_bytes;
    logic [31:0]        to_4k_beats;
    logic [31:0]        burst_beats;
    logic               unused_bid;

    assign unused_bid = ^m_bid;

    // Beats that still fit before the next 4 KB page; addr_q is always beat aligned.
    assign to_4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign to_4k_beats = 32'(to_4k_bytes >> SIZE);

    always_comb begin
        burst_beats = beats_left_q;
        if (burst_beats > 32'(MAX_BURST)) begin
            burst_beats = 32'(MAX_BURST);
        end
        if (burst_beats > to_4k_beats) begin
            burst_beats = to_4k_beats;
        end
    end

    assign cfg_misaligned = (cfg_addr[SIZE-1:0] != '0) || (cfg_len[SIZE-1:0] != '0);

    assign in_data = (state_q == DATA);

    // awvalid only rises with a free outstanding slot; the count cannot grow
    // again until this AW is accepted, so awvalid is never withdrawn early.
    assign m_awvalid = (state_q == ADDR) && (outstanding_q != OUT_MAX);
    assign m_awaddr  = addr_q;
    assign m_awlen   = 4'(burst_beats - 32'd1);
    assign m_awid    = '0;
    assign m_awsize  = 3'(SIZE);
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awprot  = 3'b000;
    assign m_awcache = AWCACHE;
    assign m_awuser  = AWUSER;

    assign m_wid     = '0;
    assign m_wdata   = s_data;
    assign m_wstrb   = '1;
    assign m_wvalid  = s_valid & in_data;
    assign s_ready   = m_wready & in_data;
    assign m_wlast   = in_data && (beat_cnt_q == burst_q - 5'd1);

    assign m_bready  = ~reset;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;

    assign sts_busy    = (state_q != IDLE);
    assign sts_done    = done_q;
    assign sts_err     = err_q;
    assign sts_cfg_err = cfg_err_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beats_left_d  = beats_left_q;
        burst_d       = burst_q;
        beat_cnt_d    = beat_cnt_q;
        outstanding_d = outstanding_q;
        done_d        = done_q;
        err_d         = err_q;
        cfg_err_d     = cfg_err_q;

        case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Only the first error response of a transfer is kept.
        if (b_hs && (err_q == 2'b00) && (m_bresp != 2'b00)) begin
            err_d = m_bresp;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    err_d = 2'b00;
                    if (cfg_misaligned) begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (cfg_len == 32'd0) begin
                        cfg_err_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        cfg_err_d    = 1'b0;
                        done_d       = 1'b0;
                        addr_d       = cfg_addr;
                        beats_left_d = cfg_len >> SIZE;
                        state_d      = ADDR;
                    end
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    addr_d       = addr_q + (ADDR_W'(burst_beats) << SIZE);
                    beats_left_d = beats_left_q - burst_beats;
                    burst_d      = 5'(burst_beats);
                    beat_cnt_d   = 5'd0;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    if (m_wlast) begin
                        state_d = (beats_left_q == 32'd0) ? DRAIN : ADDR;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            beats_left_q  <= '0;
            burst_q       <= '0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 2'b00;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beats_left_q  <= beats_left_d;
            burst_q       <= burst_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            err_q         <= err_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

endmodule
